// File: rtl/morse_tx_pkg.sv
// Shared types and constants for the Morse letter transmitter.
// The letter table covers A..H; element timing is in time-base ticks.
package morse_tx_pkg;

    localparam int unsigned DOT_UNITS        = 1;
    localparam int unsigned DASH_UNITS       = 3;
    localparam int unsigned GAP_UNITS        = 1;
    localparam int unsigned LETTER_GAP_UNITS = 3;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned PAT_W  = 4;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned UNIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_LGAP = 2'd3
    } state_t;

    // Element pattern is MSB first, 1 = dash; len counts valid elements.
    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic [LEN_W-1:0] len;
    } letter_code_t;

    function automatic letter_code_t letter_lookup(input logic [SEL_W-1:0] sel);
        letter_code_t code;
        case (sel)
            3'd0:    code = '{pattern: 4'b0100, len: 3'd2};  // A .-
            3'd1:    code = '{pattern: 4'b1000, len: 3'd4};  // B -...
            3'd2:    code = '{pattern: 4'b1010, len: 3'd4};  // C -.-.
            3'd3:    code = '{pattern: 4'b1000, len: 3'd3};  // D -..
            3'd4:    code = '{pattern: 4'b0000, len: 3'd1};  // E .
            3'd5:    code = '{pattern: 4'b0010, len: 3'd4};  // F ..-.
            3'd6:    code = '{pattern: 4'b1100, len: 3'd3};  // G --.
            default: code = '{pattern: 4'b0000, len: 3'd4};  // H ....
        endcase
        return code;
    endfunction

    function automatic logic [UNIT_W-1:0] element_units(input logic is_dash);
        return is_dash ? UNIT_W'(DASH_UNITS) : UNIT_W'(DOT_UNITS);
    endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// Combinational letter code lookup: letter_sel -> {pattern, len}.
module morse_letter_rom
    import morse_tx_pkg::*;
(
    input  logic [SEL_W-1:0] letter_sel_i,
    output letter_code_t     code_c
);

    always_comb begin
        code_c = letter_lookup(letter_sel_i);
    end

endmodule

// File: rtl/morse_letter_tx.sv
// Keys one Morse letter (A..H) onto an LED, paced by the external unit tick.
// Optional MORSE_TX_LETTER_GAP_EN appends an inter-letter silence before done.
module morse_letter_tx
    import morse_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic [SEL_W-1:0] letter_sel,
    output logic             tick_en,
    output logic             led,
    output logic             busy,
    output logic             done
);

    letter_code_t      code_c;
    state_t            state_q;
    logic [PAT_W-1:0]  pattern_q;
    logic [LEN_W-1:0]  elem_left_q;
    logic [UNIT_W-1:0] unit_q;
    logic              led_q;
    logic              busy_q;
    logic              tick_en_q;
    logic              done_q;

    morse_letter_rom u_rom (
        .letter_sel_i (letter_sel),
        .code_c       (code_c)
    );

    // pattern_q[PAT_W-1] always holds the element being keyed or about to be keyed;
    // it is shifted as each element finishes so the gap phase already sees the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pattern_q   <= '0;
            elem_left_q <= '0;
            unit_q      <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            tick_en_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_ON;
                        pattern_q   <= code_c.pattern;
                        elem_left_q <= code_c.len - LEN_W'(1);
                        unit_q      <= element_units(code_c.pattern[PAT_W-1]);
                        led_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        tick_en_q   <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (unit_q != UNIT_W'(1)) begin
                            unit_q <= unit_q - UNIT_W'(1);
                        end else if (elem_left_q != '0) begin
                            state_q   <= ST_OFF;
                            led_q     <= 1'b0;
                            unit_q    <= UNIT_W'(GAP_UNITS);
                            pattern_q <= {pattern_q[PAT_W-2:0], 1'b0};
                        end else begin
`ifdef MORSE_TX_LETTER_GAP_EN
                            state_q <= ST_LGAP;
                            led_q   <= 1'b0;
                            unit_q  <= UNIT_W'(LETTER_GAP_UNITS);
`else
                            state_q   <= ST_IDLE;
                            led_q     <= 1'b0;
                            busy_q    <= 1'b0;
                            tick_en_q <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (unit_q != UNIT_W'(1)) begin
                            unit_q <= unit_q - UNIT_W'(1);
                        end else begin
                            state_q     <= ST_ON;
                            led_q       <= 1'b1;
                            unit_q      <= element_units(pattern_q[PAT_W-1]);
                            elem_left_q <= elem_left_q - LEN_W'(1);
                        end
                    end
                end
`ifdef MORSE_TX_LETTER_GAP_EN
                ST_LGAP: begin
                    if (tick) begin
                        if (unit_q != UNIT_W'(1)) begin
                            unit_q <= unit_q - UNIT_W'(1);
                        end else begin
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            tick_en_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q   <= ST_IDLE;
                    led_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    tick_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick_en = tick_en_q;
    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_morse_letter_tx.sv
// Self-checking bench for morse_letter_tx: table-driven letters, random letters
// against a string-based Morse model, and hand-written reset/start corner cases.
module tb_morse_letter_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       start;
    logic [2:0] letter_sel;
    logic       tick_en;
    logic       led;
    logic       busy;
    logic       done;
    logic       tick_force;
    logic [3:0] tb_cnt = 4'd9;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int BUDGET = 400;

    morse_letter_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .start      (start),
        .letter_sel (letter_sel),
        .tick_en    (tick_en),
        .led        (led),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Time base: 10-cycle down-counter, holds its residue while disabled.
    always @(posedge clk) begin
        if (tick_en) tb_cnt <= (tb_cnt == 4'd0) ? 4'd9 : tb_cnt - 4'd1;
    end
    assign tick = (tick_en && tb_cnt == 4'd0) || tick_force;

    typedef struct {
        int sel;
        int exp_rises;
        int exp_on_ticks;
    } vec_t;

    vec_t  vecs[8];
    string morse[8];
    int    exp_q[$];
    int    obs_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic string q2s(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    // Expected LED segments in ticks: +n on, -n off (while busy).
    function automatic void model(input int sel);
        string code = morse[sel];
        exp_q.delete();
        for (int i = 0; i < code.len(); i++) begin
            exp_q.push_back(code.getc(i) == "-" ? 3 : 1);
            if (i != code.len() - 1) exp_q.push_back(-1);
        end
`ifdef MORSE_TX_LETTER_GAP_EN
        exp_q.push_back(-3);
`endif
    endfunction

    function automatic int lookup_idx(input int sel);
        foreach (vecs[i]) if (vecs[i].sel == sel) return i;
        return 0;
    endfunction

    task automatic launch(input int sel);
        letter_sel = 3'(sel);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("launch_%0d busy/led/tick_en", sel),
              int'({busy, led, tick_en}), 7);
    endtask

    // Observe one letter from the cycle after launch until busy falls.
    task automatic observe(input int sel, input bit perturb);
        int  idx       = lookup_idx(sel);
        bit  finished  = 1'b0;
        bit  prev_led  = 1'b0;
        bit  cur_level = 1'b1;
        int  cur_ticks = 0;
        int  rises     = 0;
        int  on_ticks  = 0;
        int  te_bad    = 0;
        obs_q.delete();
        for (int c = 0; c < BUDGET; c++) begin
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (led && !prev_led) rises++;
            if (led != cur_level) begin
                obs_q.push_back(cur_level ? cur_ticks : -cur_ticks);
                cur_level = led;
                cur_ticks = 0;
            end
            if (tick) begin
                cur_ticks++;
                if (led) on_ticks++;
            end
            if (tick_en !== busy) te_bad++;
            prev_led = led;
            if (perturb) begin
                if (c == 20) begin
                    start      = 1'b1;
                    letter_sel = 3'd6;
                end else if (c == 21) begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        obs_q.push_back(cur_level ? cur_ticks : -cur_ticks);
        model(sel);
        check($sformatf("letter_%0d finished", sel), int'(finished), 1);
        check($sformatf("letter_%0d done_with_busy_fall", sel), int'({done, led}), 2);
        n_checks++;
        if (q2s(obs_q) != q2s(exp_q)) begin
            n_fail++;
            $display("FAIL letter_%0d segments: got [%s], expected [%s]", sel, q2s(obs_q), q2s(exp_q));
        end
        check($sformatf("letter_%0d rises", sel), rises, vecs[idx].exp_rises);
        check($sformatf("letter_%0d on_ticks", sel), on_ticks, vecs[idx].exp_on_ticks);
        check($sformatf("letter_%0d tick_en_follows_busy", sel), te_bad, 0);
    endtask

    task automatic quiet(input string name, input int n);
        int dn = 0;
        int bs = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bs++;
        end
        check({name, " extra_done"}, dn, 0);
        check({name, " extra_busy"}, bs, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        morse = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
        vecs[0] = '{sel: 0, exp_rises: 2, exp_on_ticks: 4};
        vecs[1] = '{sel: 1, exp_rises: 4, exp_on_ticks: 6};
        vecs[2] = '{sel: 2, exp_rises: 4, exp_on_ticks: 8};
        vecs[3] = '{sel: 3, exp_rises: 3, exp_on_ticks: 5};
        vecs[4] = '{sel: 4, exp_rises: 1, exp_on_ticks: 1};
        vecs[5] = '{sel: 5, exp_rises: 4, exp_on_ticks: 6};
        vecs[6] = '{sel: 6, exp_rises: 3, exp_on_ticks: 7};
        vecs[7] = '{sel: 7, exp_rises: 4, exp_on_ticks: 4};

        reset_n    = 1'b0;
        start      = 1'b0;
        letter_sel = 3'd0;
        tick_force = 1'b0;
        repeat (3) @(negedge clk);
        check("reset led", int'(led), 0);
        check("reset busy", int'(busy), 0);
        check("reset tick_en", int'(tick_en), 0);
        check("reset done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of letter A's first on phase.
        launch(0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset led/busy/tick_en/done", int'({led, busy, tick_en, done}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet("after_midreset", 40);
        launch(4);
        observe(4, 1'b0);
        quiet("post_reset_E", 5);

        // Tick while idle must not start or disturb anything.
        tick_force = 1'b1;
        @(negedge clk);
        tick_force = 1'b0;
        check("idle_tick busy/led/done", int'({busy, led, done}), 0);
        launch(4);
        observe(4, 1'b0);
        quiet("idle_tick_E", 5);

        foreach (vecs[i]) begin
            launch(vecs[i].sel);
            observe(vecs[i].sel, 1'b0);
            quiet($sformatf("table_%0d", vecs[i].sel), 3);
        end

        // start and letter_sel disturbed mid-B: B unchanged, nothing queued.
        launch(1);
        observe(1, 1'b1);
        quiet("perturbed_B", 40);

        // start asserted during the done cycle is accepted.
        launch(4);
        observe(4, 1'b0);
        launch(0);
        observe(0, 1'b0);
        quiet("chained_A", 5);

        for (int r = 0; r < 20; r++) begin
            int sel = int'($urandom_range(7, 0));
            repeat ($urandom_range(4, 0)) @(negedge clk);
            launch(sel);
            observe(sel, 1'b0);
        end
        quiet("random_tail", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
